// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) used on every side of axi_rd_arbiter.
//   master modport : drives AR request fields and rready, receives arready and R beats
//   slave  modport : receives AR request fields and rready, drives arready and R beats
// Parameters: ADDR_WIDTH (AR address width), DATA_WIDTH (R data width).
interface axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) ();
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic [1:0]            arburst;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rlast;
  logic                  rready;

  modport master (
    output araddr, arvalid, arburst, arlen, arsize, rready,
    input  arready, rdata, rresp, rvalid, rlast
  );

  modport slave (
    input  araddr, arvalid, arburst, arlen, arsize, rready,
    output arready, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI4 read arbiter. One AR+R transaction is owned at a
// time; R beats are routed back to the owner and the beat count is checked
// against the granted arlen.
//   clk, rst : clock, synchronous active-high reset
//   m1       : instruction-fetch master (slave modport, we answer it)
//   m2       : memory-stage master      (slave modport, we answer it)
//   s        : memory port              (master modport, we drive it)
//   beat_err : sticky flag, burst length did not match arlen; cleared by rst
// Build option ARB_RR_EN: when defined, ties alternate between masters
// (master 2 wins the first tie); when undefined, master 2 always wins ties.
module axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  axi_rd_arbiter_if.slave   m1,
  axi_rd_arbiter_if.slave   m2,
  axi_rd_arbiter_if.master  s,
  output logic              beat_err
);

  typedef enum logic [2:0] {IDLE, AR1, AR2, R1, R2} state_t;

  state_t     state_q, state_d;
  logic [7:0] len_q;
  logic [7:0] beat_cnt;
  logic       pick2;
  logic       ar_hs;
  logic       r_hs;

`ifdef ARB_RR_EN
  // last_grant = 1 means master 1 owned the previous grant, so master 2 wins
  // the next tie; the reset value hands the first tie to master 2.
  logic last_grant;

  assign pick2 = m2.arvalid & (~m1.arvalid | last_grant);

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (state_q == IDLE && state_d == AR1)
      last_grant <= 1'b1;
    else if (state_q == IDLE && state_d == AR2)
      last_grant <= 1'b0;
  end
`else
  assign pick2 = m2.arvalid;
`endif

  assign ar_hs = s.arready & ((state_q == AR1 & m1.arvalid) |
                              (state_q == AR2 & m2.arvalid));
  assign r_hs  = s.rvalid  & ((state_q == R1 & m1.rready) |
                              (state_q == R2 & m2.rready));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (m1.arvalid | m2.arvalid) state_d = pick2 ? AR2 : AR1;
      AR1:  if (m1.arvalid & s.arready) state_d = R1;
      AR2:  if (m2.arvalid & s.arready) state_d = R2;
      R1:   if (s.rvalid & m1.rready & s.rlast) state_d = IDLE;
      R2:   if (s.rvalid & m2.rready & s.rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: pure mux of the owner onto the slave and back; everything not
  // owned is held at 0
  always_comb begin
    s.araddr   = {ADDR_WIDTH{1'b0}};
    s.arvalid  = 1'b0;
    s.arburst  = 2'b0;
    s.arlen    = 8'd0;
    s.arsize   = 3'd0;
    s.rready   = 1'b0;
    m1.arready = 1'b0;
    m1.rdata   = {DATA_WIDTH{1'b0}};
    m1.rresp   = 2'b0;
    m1.rvalid  = 1'b0;
    m1.rlast   = 1'b0;
    m2.arready = 1'b0;
    m2.rdata   = {DATA_WIDTH{1'b0}};
    m2.rresp   = 2'b0;
    m2.rvalid  = 1'b0;
    m2.rlast   = 1'b0;
    case (state_q)
      AR1: begin
        s.araddr   = m1.araddr;
        s.arvalid  = m1.arvalid;
        s.arburst  = m1.arburst;
        s.arlen    = m1.arlen;
        s.arsize   = m1.arsize;
        m1.arready = s.arready;
      end
      AR2: begin
        s.araddr   = m2.araddr;
        s.arvalid  = m2.arvalid;
        s.arburst  = m2.arburst;
        s.arlen    = m2.arlen;
        s.arsize   = m2.arsize;
        m2.arready = s.arready;
      end
      R1: begin
        m1.rdata  = s.rdata;
        m1.rresp  = s.rresp;
        m1.rvalid = s.rvalid;
        m1.rlast  = s.rlast;
        s.rready  = m1.rready;
      end
      R2: begin
        m2.rdata  = s.rdata;
        m2.rresp  = s.rresp;
        m2.rvalid = s.rvalid;
        m2.rlast  = s.rlast;
        s.rready  = m2.rready;
      end
      default: ;
    endcase
  end

  // burst bookkeeping: beat_cnt is the index of the beat being accepted, so
  // the rlast beat must arrive exactly when beat_cnt == len_q
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= 8'd0;
      beat_cnt <= 8'd0;
      beat_err <= 1'b0;
    end else begin
      if (ar_hs) begin
        len_q    <= (state_q == AR2) ? m2.arlen : m1.arlen;
        beat_cnt <= 8'd0;
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (s.rlast ? (beat_cnt != len_q) : (beat_cnt == len_q))
          beat_err <= 1'b1;
      end
    end
  end

endmodule
